// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half adders and an OR; purely
// combinational and the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_s_s;
    logic ha1_c_s;
    logic ha2_c_s;

    assign ha1_s_s = a ^ b;
    assign ha1_c_s = a & b;
    assign s       = ha1_s_s ^ ci;
    assign ha2_c_s = ha1_s_s & ci;
    assign co      = ha1_c_s | ha2_c_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sequences operand bits LSB-first through a single
// full-adder cell, with a carry flip-flop closing the loop between bits.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_sh_r;
    logic [WIDTH-1:0]   res_sh_nxt_s;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               load_s;
    logic               shift_s;
    logic               finish_s;
    logic               fa_s_s;
    logic               fa_co_s;

    fa_cell u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_sh_nxt_s = (res_sh_r >> 1) | (WIDTH'(fa_s_s) << (WIDTH - 1));

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_SHIFT);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand shift registers, carry loop, bit counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (shift_s) begin
            a_sh_r   <= a_sh_r >> 1;
            b_sh_r   <= b_sh_r >> 1;
            res_sh_r <= res_sh_nxt_s;
            carry_r  <= fa_co_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            res_sh_r <= res_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Result outputs update only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (finish_s) begin
            sum_r  <= res_sh_nxt_s;
            cout_r <= fa_co_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed cases and a WIDTH=4
// exhaustive sweep, each checked against a cycle-level behavioural model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic       cin8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic       cin4 = 1'b0;
    logic [3:0] a4 = 4'h0;
    logic [3:0] b4 = 4'h0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .cout(cout4), .sum(sum4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start at edge e0 means busy after edges e0..e0+W-1,
    // done after edge e0+W (which also publishes a+b+cin), and a new start is
    // accepted again from edge e0+W+1 onward.
    bit         op_m[2];
    int         e0_m[2];
    logic [8:0] pend_m[2];
    logic [8:0] res_m[2];
    bit         exp_busy[2];
    bit         exp_done[2];

    initial begin
        int w, d;
        bit st;
        logic [8:0] sv;
        for (int u = 0; u < 2; u++) begin
            op_m[u] = 1'b0; res_m[u] = 9'd0; exp_busy[u] = 1'b0; exp_done[u] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int u = 0; u < 2; u++) begin
                    op_m[u] = 1'b0; res_m[u] = 9'd0; exp_busy[u] = 1'b0; exp_done[u] = 1'b0;
                end
            end else begin
                cyc++;
                for (int u = 0; u < 2; u++) begin
                    w  = (u == 0) ? 8 : 4;
                    st = (u == 0) ? start8 : start4;
                    sv = (u == 0) ? (9'(a8) + 9'(b8) + 9'(cin8))
                                  : (9'(a4) + 9'(b4) + 9'(cin4));
                    d  = op_m[u] ? (cyc - e0_m[u]) : (w + 5);
                    if (op_m[u] && d == w) res_m[u] = pend_m[u];
                    if (st && (!op_m[u] || d >= w + 1)) begin
                        op_m[u] = 1'b1; e0_m[u] = cyc; pend_m[u] = sv;
                    end
                    d = op_m[u] ? (cyc - e0_m[u]) : (w + 5);
                    exp_busy[u] = (d < w);
                    exp_done[u] = (d == w);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("busy8", 32'(busy8), 32'(exp_busy[0]));
                check("done8", 32'(done8), 32'(exp_done[0]));
                check("result8", 32'({cout8, sum8}), 32'(res_m[0]));
                check("busy4", 32'(busy4), 32'(exp_busy[1]));
                check("done4", 32'(done4), 32'(exp_done[1]));
                check("result4", 32'({cout4, sum4}), 32'(res_m[1][4:0]));
            end
        end
    end

    // Waits (bounded) for done; drops start after the first edge and can
    // inject a one-cycle start pulse on the WIDTH=8 unit at cycle inj_n.
    task automatic wait_done(input int u, input int inj_n, input logic [7:0] ia,
                             input logic [7:0] ib, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (u == 0) start8 = 1'b0;
                else        start4 = 1'b0;
            end
            if (n == inj_n) begin
                a8 = ia; b8 = ib; start8 = 1'b1;
            end
            if (n == inj_n + 1) start8 = 1'b0;
            if ((u == 0) ? busy8 : busy4) busy_n++;
        end while (!((u == 0) ? done8 : done4) && n < 40);
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit gap, input int inj_n,
                        input logic [7:0] ia, input logic [7:0] ib, input logic [8:0] exp);
        int n, bn;
        if (gap) @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        wait_done(0, inj_n, ia, ib, n, bn);
        check({name, "_latency"}, 32'(n), 32'd9);
        check({name, "_busy_cycles"}, 32'(bn), 32'd8);
        check(name, 32'({cout8, sum8}), 32'(exp));
    endtask

    initial begin
        int n, bn, done_seen;
        logic [4:0] exp4;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum", 32'(sum8), 32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;

        run8("zero",    8'h00, 8'h00, 1'b0, 1'b1, -1, 8'h00, 8'h00, 9'h000);
        run8("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b1, -1, 8'h00, 8'h00, 9'h100);
        run8("a5_p_5a", 8'hA5, 8'h5A, 1'b1, 1'b1, -1, 8'h00, 8'h00, 9'h100);
        run8("ignored_start", 8'h12, 8'h34, 1'b0, 1'b1, 3, 8'hFF, 8'hFF, 9'h046);
        repeat (4) @(negedge clk);
        check("hold_sum", 32'(sum8), 32'h46);
        check("hold_busy", 32'(busy8), 32'd0);

        run8("b2b_first",  8'h80, 8'h80, 1'b0, 1'b1, -1, 8'h00, 8'h00, 9'h100);
        run8("b2b_second", 8'h01, 8'h02, 1'b1, 1'b0, -1, 8'h00, 8'h00, 9'h004);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run8("after_abort", 8'h55, 8'h0F, 1'b0, 1'b0, -1, 8'h00, 8'h00, 9'h064);

        // Exhaustive WIDTH=4 sweep, issued back-to-back from the DONE cycle.
        @(negedge clk);
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    exp4 = 5'(ia + ib + ic);
                    wait_done(1, -1, 8'h00, 8'h00, n, bn);
                    check("sweep4_latency", 32'(n), 32'd5);
                    check("sweep4_result", 32'({cout4, sum4}), 32'(exp4));
                end
            end
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete within 1000000 time units");
        $fatal(1, "timeout");
    end

endmodule
